ff_phase_responder: RTL and testbench
=====================================

Name: ff_phase_responder

Overview:
- Responder end of the phase-sequencing interface.
- A sequencer issues phase commands (positive pass, negative pass, inference) over a valid/ready request channel.
- This block runs T_STEPS spike timesteps for the accepted phase and counts input spikes.
- It returns the spike count on a valid/ready response channel; it sits between the phase sequencer and the layer goodness/update logic.

Parameters:
- T_STEPS, 10, timesteps per phase; legal range 1..2**CNT_W-1.
- CNT_W, 8, width of the timestep counter and the spike counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  phase command valid.
- req_ready  out  1  responder can accept a command.
- req_phase  in  2  00=POS, 01=NEG, 10=INFER, 11=reserved.
- spike_in_valid  in  1  one timestep's spike sample is present.
- spike_in  in  1  spike bit for the current timestep.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  consumer accepts the result.
- rsp_phase  out  2  phase of the reported result.
- rsp_count  out  CNT_W  spikes counted during the phase.
- busy  out  1  high whenever the FSM is not in IDLE.
- state  out  2  current FSM state, for debug.

Behaviour:
- Reset (asynchronous, immediate, also mid-operation):
  - state=IDLE; step_cnt=0; spike_cnt=0.
  - rsp_valid=0, rsp_phase=0, rsp_count=0, busy=0.
  - Any in-flight phase is discarded and no response is emitted.
- FSM encoding: IDLE=00, RUN=01, REPORT=10; the unused code 11 returns to IDLE on the next clock.
- IDLE:
  - req_ready=1, driven combinationally from state==IDLE; req_ready=0 in every other state.
  - When req_valid&&req_ready: latch req_phase and clear step_cnt and spike_cnt.
  - Next state is RUN for phases 00/01/10.
  - Phase 11 goes directly to REPORT with rsp_count=0.
- RUN:
  - Each cycle with spike_in_valid=1 is one timestep: step_cnt+1 and spike_cnt+spike_in.
  - spike_cnt saturates at 2**CNT_W-1 and never wraps.
  - Cycles with spike_in_valid=0 are stalls; counters hold.
  - When the accepted timestep has step_cnt==T_STEPS-1:
    - Move to REPORT.
    - Load rsp_count with the final count, including that timestep's spike.
    - Load rsp_phase.
- REPORT:
  - rsp_valid=1 starting the cycle after the last timestep (latency 1).
  - rsp_phase and rsp_count are registered and held stable while rsp_valid&&!rsp_ready.
  - On rsp_ready=1: rsp_valid=0 next cycle and state=IDLE.
  - A new request can be accepted the cycle after returning to IDLE; there is no same-cycle turnaround.
- spike_in_valid is ignored in IDLE and REPORT.
- req_valid is ignored while req_ready=0; the sequencer must hold it.
- Total latency from acceptance to rsp_valid: T_STEPS+1 cycles, with no stalls and rsp_ready high.

Optional Feature:
- Macro: FF_PHASE_THRESH_EN.
- When defined:
  - Adds parameter THRESH (default 5).
  - Adds output rsp_above (1 bit), registered with rsp_count: rsp_above = (final count >= THRESH).
  - rsp_above resets to 0 and is held with rsp_count during backpressure.
- When undefined: the parameter and port are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package ff_phase_pkg:
  - State encodings IDLE/RUN/REPORT.
  - Phase codes PHASE_POS, PHASE_NEG, PHASE_INFER, PHASE_RSVD.
  - Default T_STEPS and CNT_W constants.
- One sub-module: ff_sat_counter.
  - CNT_W-bit counter with clear, enable, increment input and saturation.
  - Instantiated for spike_cnt; step_cnt stays inline.

Test Plan:
- Reset, then req_valid with phase 00 and 10 consecutive spike_in=1 steps -> rsp_valid 1 cycle after the 10th step, rsp_phase=00, rsp_count=10.
- Phase 01 with spike pattern 1,0,1,0,… over 10 steps, with spike_in_valid dropped for 3 cycles mid-run -> rsp_count=5; acceptance to rsp_valid = 14 cycles.
- rsp_ready held low 4 cycles in REPORT -> rsp_valid, rsp_phase and rsp_count stable throughout; req_ready=0 throughout; IDLE one cycle after rsp_ready=1.
- req_phase=11 -> REPORT next cycle, rsp_count=0, no timesteps consumed.
- CNT_W=3, T_STEPS=7, all spikes=1 -> rsp_count saturates at 7; same setup with T_STEPS=10 is illegal and is not tested.
- rst_n pulsed low in RUN at step 4 -> immediately state=00, busy=0, rsp_valid=0; the next phase 10 with 10 spikes reports 10, with no residue from the aborted phase.
- With FF_PHASE_THRESH_EN and THRESH=5: count 4 -> rsp_above=0; count 5 -> rsp_above=1.

Source files
------------

// File: rtl/ff_phase_pkg.sv
// Shared encodings and defaults for the phase-sequencing responder.
package ff_phase_pkg;
  localparam int T_STEPS_DEF = 10;
  localparam int CNT_W_DEF   = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    REPORT = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    PHASE_POS   = 2'b00,
    PHASE_NEG   = 2'b01,
    PHASE_INFER = 2'b10,
    PHASE_RSVD  = 2'b11
  } phase_t;
endpackage

// File: rtl/ff_sat_counter.sv
// W-bit up-counter with synchronous clear and saturation at all-ones.
// count_next exposes the value being loaded so callers can capture it same-cycle.
module ff_sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic [W-1:0] count_next
);
  localparam logic [W-1:0] MAX = '1;

  always_comb begin
    count_next = count;
    if (clr)
      count_next = '0;
    else if (en && inc && (count != MAX))
      count_next = count + W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count <= '0;
    else        count <= count_next;
  end
endmodule

// File: rtl/ff_phase_responder.sv
// Responder for phase commands: runs T_STEPS spike timesteps and reports the spike count.
// Optional FF_PHASE_THRESH_EN adds THRESH and a registered rsp_above flag.
module ff_phase_responder
  import ff_phase_pkg::*;
#(
  parameter int T_STEPS = T_STEPS_DEF,
  parameter int CNT_W   = CNT_W_DEF
`ifdef FF_PHASE_THRESH_EN
  , parameter int THRESH = 5
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_phase,
  input  logic             spike_in_valid,
  input  logic             spike_in,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [1:0]       rsp_phase,
  output logic [CNT_W-1:0] rsp_count,
`ifdef FF_PHASE_THRESH_EN
  output logic             rsp_above,
`endif
  output logic             busy,
  output logic [1:0]       state
);
  state_t           state_q, state_d;
  logic [1:0]       phase_q;
  logic [CNT_W-1:0] step_cnt;
  logic [CNT_W-1:0] spike_cnt, spike_next;
  logic             accept, step, last_step;

  assign accept    = req_valid && req_ready;
  assign step      = (state_q == RUN) && spike_in_valid;
  assign last_step = (step_cnt == CNT_W'(T_STEPS - 1));
  assign state     = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    busy      = 1'b1;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid)
          state_d = (req_phase == PHASE_RSVD) ? REPORT : RUN;
      end
      RUN:    if (spike_in_valid && last_step) state_d = REPORT;
      REPORT: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  ff_sat_counter #(.W(CNT_W)) u_spike_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (accept),
    .en         (step),
    .inc        (spike_in),
    .count      (spike_cnt),
    .count_next (spike_next)
  );

  // Result registers only move on a reserved-phase accept or the final timestep,
  // so they hold naturally under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q   <= 2'b00;
      step_cnt  <= '0;
      rsp_phase <= 2'b00;
      rsp_count <= '0;
`ifdef FF_PHASE_THRESH_EN
      rsp_above <= 1'b0;
`endif
    end else if (accept) begin
      phase_q  <= req_phase;
      step_cnt <= '0;
      if (req_phase == PHASE_RSVD) begin
        rsp_phase <= req_phase;
        rsp_count <= '0;
`ifdef FF_PHASE_THRESH_EN
        rsp_above <= (THRESH <= 0);
`endif
      end
    end else if (step) begin
      step_cnt <= step_cnt + CNT_W'(1);
      if (last_step) begin
        rsp_phase <= phase_q;
        rsp_count <= spike_next;
`ifdef FF_PHASE_THRESH_EN
        rsp_above <= (int'(spike_next) >= THRESH);
`endif
      end
    end
  end
endmodule

// File: tb/tb_ff_phase_responder.sv
// Self-checking bench for ff_phase_responder; rsp_above checks need FF_PHASE_THRESH_EN.
module tb_ff_phase_responder;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       req_valid, req_ready, spike_in_valid, spike_in, rsp_valid, rsp_ready, busy;
  logic [1:0] req_phase, rsp_phase, state;
  logic [7:0] rsp_count;
  logic       b_req_valid, b_req_ready, b_spike_in_valid, b_spike_in, b_rsp_valid, b_rsp_ready, b_busy;
  logic [1:0] b_req_phase, b_rsp_phase, b_state;
  logic [2:0] b_rsp_count;
`ifdef FF_PHASE_THRESH_EN
  logic       rsp_above, b_rsp_above;
`endif

  int errs = 0;
  int checks = 0;

  ff_phase_responder #(.T_STEPS(10), .CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_phase(req_phase), .spike_in_valid(spike_in_valid), .spike_in(spike_in),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_phase(rsp_phase),
    .rsp_count(rsp_count),
`ifdef FF_PHASE_THRESH_EN
    .rsp_above(rsp_above),
`endif
    .busy(busy), .state(state)
  );

  ff_phase_responder #(.T_STEPS(7), .CNT_W(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_phase(b_req_phase), .spike_in_valid(b_spike_in_valid), .spike_in(b_spike_in),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_phase(b_rsp_phase),
    .rsp_count(b_rsp_count),
`ifdef FF_PHASE_THRESH_EN
    .rsp_above(b_rsp_above),
`endif
    .busy(b_busy), .state(b_state)
  );

  task automatic do_cycle();
    @(posedge clk);
    #1;
  endtask

  // Issue one command, then play pat (0/1 = timestep with that spike, 2 = stall);
  // once pat is exhausted, keep feeding spike-free timesteps. lat counts cycles from
  // the acceptance cycle (cycle 0) to the first cycle rsp_valid is seen.
  task automatic drive_phase(input logic [1:0] ph, input int pat[$], output int lat);
    int idx = 0;
    req_phase = ph;
    req_valid = 1'b1;
    do_cycle();
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat <= 200) begin
      if (idx < pat.size()) begin
        spike_in_valid = (pat[idx] != 2);
        spike_in       = (pat[idx] == 1);
        idx++;
      end else begin
        spike_in_valid = 1'b1;
        spike_in       = 1'b0;
      end
      do_cycle();
      lat++;
    end
    spike_in_valid = 1'b0;
    spike_in       = 1'b0;
  endtask

  task automatic release_rsp();
    rsp_ready = 1'b1;
    do_cycle();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 0; req_phase = 0; spike_in_valid = 0; spike_in = 0; rsp_ready = 0;
    b_req_valid = 0; b_req_phase = 0; b_spike_in_valid = 0; b_spike_in = 0; b_rsp_ready = 0;
    repeat (2) do_cycle();
    checks++; if (state !== 2'b00) begin errs++; $display("FAIL reset_state got=%0d exp=0", state); end
    checks++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (rsp_valid !== 1'b0) begin errs++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    checks++; if (rsp_count !== 8'd0) begin errs++; $display("FAIL reset_rsp_count got=%0d exp=0", rsp_count); end
    checks++; if (rsp_phase !== 2'b00) begin errs++; $display("FAIL reset_rsp_phase got=%0d exp=0", rsp_phase); end
    checks++; if (req_ready !== 1'b1) begin errs++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
`ifdef FF_PHASE_THRESH_EN
    checks++; if (rsp_above !== 1'b0) begin errs++; $display("FAIL reset_rsp_above got=%b exp=0", rsp_above); end
`endif
    rst_n = 1'b1;
    do_cycle();
  endtask

  task automatic test_pos_all_ones();
    int lat;
    int pat[$];
    for (int i = 0; i < 10; i++) pat.push_back(1);
    drive_phase(2'b00, pat, lat);
    checks++; if (lat !== 11) begin errs++; $display("FAIL pos_latency got=%0d exp=11", lat); end
    checks++; if (rsp_phase !== 2'b00) begin errs++; $display("FAIL pos_phase got=%0d exp=0", rsp_phase); end
    checks++; if (rsp_count !== 8'd10) begin errs++; $display("FAIL pos_count got=%0d exp=10", rsp_count); end
    release_rsp();
    checks++; if (state !== 2'b00 || rsp_valid !== 1'b0) begin
      errs++; $display("FAIL pos_return_idle got state=%0d valid=%b exp state=0 valid=0", state, rsp_valid);
    end
  endtask

  task automatic test_stall_and_backpressure();
    int lat;
    int pat[$] = '{1, 0, 1, 0, 1, 2, 2, 2, 0, 1, 0, 1, 0};
    drive_phase(2'b01, pat, lat);
    checks++; if (lat !== 14) begin errs++; $display("FAIL stall_latency got=%0d exp=14", lat); end
    checks++; if (rsp_count !== 8'd5) begin errs++; $display("FAIL stall_count got=%0d exp=5", rsp_count); end
    // a new command held during REPORT must not be taken
    req_valid = 1'b1;
    req_phase = 2'b10;
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_phase !== 2'b01 || rsp_count !== 8'd5 || req_ready !== 1'b0) begin
        errs++;
        $display("FAIL bp_hold cyc=%0d got valid=%b phase=%0d count=%0d ready=%b exp 1/1/5/0",
                 c, rsp_valid, rsp_phase, rsp_count, req_ready);
      end
      do_cycle();
    end
    release_rsp();
    checks++; if (state !== 2'b00 || rsp_valid !== 1'b0) begin
      errs++; $display("FAIL bp_return_idle got state=%0d valid=%b exp state=0 valid=0", state, rsp_valid);
    end
    checks++; if (rsp_count !== 8'd5 || rsp_phase !== 2'b01) begin
      errs++; $display("FAIL bp_no_turnaround got count=%0d phase=%0d exp 5/1", rsp_count, rsp_phase);
    end
    req_valid = 1'b0;
  endtask

  task automatic test_reserved_phase();
    int lat;
    int pat[$];
    spike_in_valid = 1'b1;
    spike_in = 1'b1;
    drive_phase(2'b11, pat, lat);
    checks++; if (lat !== 1) begin errs++; $display("FAIL rsvd_latency got=%0d exp=1", lat); end
    checks++; if (state !== 2'b10) begin errs++; $display("FAIL rsvd_state got=%0d exp=2", state); end
    checks++; if (rsp_count !== 8'd0) begin errs++; $display("FAIL rsvd_count got=%0d exp=0", rsp_count); end
    checks++; if (rsp_phase !== 2'b11) begin errs++; $display("FAIL rsvd_phase got=%0d exp=3", rsp_phase); end
    release_rsp();
  endtask

  task automatic test_saturation();
    int n;
    b_req_phase = 2'b00;
    b_req_valid = 1'b1;
    do_cycle();
    b_req_valid = 1'b0;
    b_spike_in_valid = 1'b1;
    b_spike_in = 1'b1;
    n = 1;
    while (!b_rsp_valid && n < 100) begin
      do_cycle();
      n++;
    end
    b_spike_in_valid = 1'b0;
    checks++; if (n !== 8) begin errs++; $display("FAIL sat_latency got=%0d exp=8", n); end
    checks++; if (b_rsp_count !== 3'd7) begin errs++; $display("FAIL sat_count got=%0d exp=7", b_rsp_count); end
    b_rsp_ready = 1'b1;
    do_cycle();
    b_rsp_ready = 1'b0;
  endtask

  task automatic test_reset_midrun();
    int lat;
    int pat[$];
    req_phase = 2'b00;
    req_valid = 1'b1;
    do_cycle();
    req_valid = 1'b0;
    spike_in_valid = 1'b1;
    spike_in = 1'b1;
    repeat (4) do_cycle();
    #1 rst_n = 1'b0;
    #1;
    checks++; if (state !== 2'b00) begin errs++; $display("FAIL rst_mid_state got=%0d exp=0", state); end
    checks++; if (busy !== 1'b0) begin errs++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
    checks++; if (rsp_valid !== 1'b0) begin errs++; $display("FAIL rst_mid_valid got=%b exp=0", rsp_valid); end
    #1 rst_n = 1'b1;
    spike_in_valid = 1'b0;
    do_cycle();
    for (int i = 0; i < 10; i++) pat.push_back(1);
    drive_phase(2'b10, pat, lat);
    checks++; if (lat !== 11) begin errs++; $display("FAIL rst_after_latency got=%0d exp=11", lat); end
    checks++; if (rsp_count !== 8'd10 || rsp_phase !== 2'b10) begin
      errs++; $display("FAIL rst_after_result got count=%0d phase=%0d exp 10/2", rsp_count, rsp_phase);
    end
    release_rsp();
  endtask

  task automatic test_threshold();
    int lat;
    for (int k = 4; k <= 5; k++) begin
      int pat[$];
      for (int i = 0; i < 10; i++) pat.push_back(i < k ? 1 : 0);
      drive_phase(2'b00, pat, lat);
      checks++; if (rsp_count !== 8'(k)) begin errs++; $display("FAIL thr_count got=%0d exp=%0d", rsp_count, k); end
`ifdef FF_PHASE_THRESH_EN
      checks++; if (rsp_above !== (k >= 5)) begin
        errs++; $display("FAIL thr_above count=%0d got=%b exp=%b", k, rsp_above, (k >= 5));
      end
`endif
      release_rsp();
    end
  endtask

  // Reference: count = number of 1-valued accepted timesteps among the first 10,
  // latency = 1 + 10 + stalls; reserved phase reports 0 after one cycle.
  task automatic test_random();
    for (int it = 0; it < 25; it++) begin
      int pat[$];
      int exp_cnt = 0, exp_lat, stalls = 0, lat, bp, b;
      logic [1:0] ph = 2'($urandom_range(0, 3));
      for (int s = 0; s < 10; s++) begin
        if ($urandom_range(0, 3) == 0) begin pat.push_back(2); stalls++; end
        b = int'($urandom_range(0, 1));
        pat.push_back(b);
        exp_cnt += b;
      end
      if (ph == 2'b11) begin exp_cnt = 0; exp_lat = 1; end
      else exp_lat = 11 + stalls;
      drive_phase(ph, pat, lat);
      checks++; if (lat !== exp_lat) begin errs++; $display("FAIL rnd_latency it=%0d got=%0d exp=%0d", it, lat, exp_lat); end
      checks++; if (rsp_count !== 8'(exp_cnt) || rsp_phase !== ph) begin
        errs++; $display("FAIL rnd_result it=%0d got count=%0d phase=%0d exp %0d/%0d", it, rsp_count, rsp_phase, exp_cnt, ph);
      end
      bp = int'($urandom_range(0, 3));
      for (int c = 0; c < bp; c++) begin
        do_cycle();
        checks++; if (rsp_valid !== 1'b1 || rsp_count !== 8'(exp_cnt)) begin
          errs++; $display("FAIL rnd_bp it=%0d got valid=%b count=%0d exp 1/%0d", it, rsp_valid, rsp_count, exp_cnt);
        end
      end
      release_rsp();
      checks++; if (state !== 2'b00) begin errs++; $display("FAIL rnd_idle it=%0d got=%0d exp=0", it, state); end
    end
  endtask

  initial begin
    test_reset();
    test_pos_all_ones();
    test_stall_and_backpressure();
    test_reserved_phase();
    test_saturation();
    test_reset_midrun();
    test_threshold();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
